// File: rtl/sift_desc_pkg.sv
// Shared constants, FSM state type and pipeline payload for the descriptor
// histogram controller.
package sift_desc_pkg;

  localparam int unsigned NUM_DIR36 = 36;
  localparam int unsigned NUM_BIN   = 8;
  localparam int unsigned NUM_SUB   = 16;
  localparam int unsigned DESC_LEN  = 128;
  localparam int unsigned ACC_W     = 16;

  localparam int unsigned DIR_W = 6;
  localparam int unsigned MAG_W = 8;
  localparam int unsigned SUB_W = 4;
  localparam int unsigned BIN_W = $clog2(NUM_BIN);
  localparam int unsigned IDX_W = $clog2(DESC_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Accepted sample after quantization, held for one cycle before the add.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [MAG_W-1:0] mag;
  } acc_req_t;

endpackage

// File: rtl/dir_quant8.sv
// Rotates a 36-step sample direction by the keypoint main direction and
// quantizes the result into one of 8 orientation bins.
// Ports: dir  - sample direction 0..35 (larger values flag err)
//        main - keypoint main direction 0..35
//        bin  - orientation bin 0..7
//        err  - dir out of range
// Config: DESC_ROT_EN defined enables rotation; otherwise main is ignored.
module dir_quant8
  import sift_desc_pkg::*;
(
  input  logic [DIR_W-1:0] dir,
  input  logic [DIR_W-1:0] main,
  output logic [BIN_W-1:0] bin,
  output logic             err
);

  localparam int unsigned DW = DIR_W + 1;

  logic [DW-1:0] diff;

`ifdef DESC_ROT_EN
  logic [DW-1:0] raw;

  // Add 36 before subtracting so the modulo needs only one conditional wrap.
  always_comb begin
    raw  = DW'(dir) + DW'(NUM_DIR36) - DW'(main);
    diff = (raw >= DW'(NUM_DIR36)) ? raw - DW'(NUM_DIR36) : raw;
  end
`else
  logic unused_main;

  assign unused_main = ^main;
  assign diff        = DW'(dir);
`endif

  assign err = (dir > DIR_W'(NUM_DIR36 - 1));

  // Bins are centred on multiples of 45 degrees; bin0 wraps around 0.
  always_comb begin
    bin = BIN_W'(0);
    if (diff >= DW'(34) || diff <= DW'(2)) bin = BIN_W'(0);
    else if (diff <= DW'(6))               bin = BIN_W'(1);
    else if (diff <= DW'(11))              bin = BIN_W'(2);
    else if (diff <= DW'(15))              bin = BIN_W'(3);
    else if (diff <= DW'(20))              bin = BIN_W'(4);
    else if (diff <= DW'(24))              bin = BIN_W'(5);
    else if (diff <= DW'(29))              bin = BIN_W'(6);
    else                                   bin = BIN_W'(7);
  end

endmodule

// File: rtl/desc_hist_ctrl.sv
// Descriptor histogram controller: accumulates sample magnitudes into a
// 16x8 orientation histogram per keypoint, then streams the 128 bins out.
// Ports: clk, rst (sync, active-high)
//        kp_start/kp_dir_main  - begin keypoint, main direction
//        s_valid/s_ready/s_dir/s_mag/s_sub/s_last - sample stream in
//        d_valid/d_ready/d_data/d_idx/d_last      - descriptor stream out
//        busy    - not IDLE
//        err_dir - pulse when a sample with s_dir>35 is dropped
// Config: DESC_ROT_EN defined rotates sample directions by kp_dir_main.
module desc_hist_ctrl
  import sift_desc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             kp_start,
  input  logic [DIR_W-1:0] kp_dir_main,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DIR_W-1:0] s_dir,
  input  logic [MAG_W-1:0] s_mag,
  input  logic [SUB_W-1:0] s_sub,
  input  logic             s_last,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [ACC_W-1:0] d_data,
  output logic [IDX_W-1:0] d_idx,
  output logic             d_last,
  output logic             busy,
  output logic             err_dir
);

  state_t           state;
  state_t           state_next;
  logic [DIR_W-1:0] dir_main;
  logic [ACC_W-1:0] acc [DESC_LEN];
  acc_req_t         pipe;
  logic             pipe_vld;
  logic [BIN_W-1:0] q_bin;
  logic             q_err;
  logic             xfer;
  logic             beat;
  logic             kp_go;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] upd;

  assign xfer  = s_valid && s_ready;
  assign beat  = d_valid && d_ready;
  assign kp_go = (state == IDLE) && kp_start;

  dir_quant8 u_quant (
    .dir  (s_dir),
    .main (dir_main),
    .bin  (q_bin),
    .err  (q_err)
  );

`ifdef DESC_ROT_EN
  // Main direction captured once per keypoint.
  always_ff @(posedge clk) begin
    if (rst)        dir_main <= '0;
    else if (kp_go) dir_main <= kp_dir_main;
  end
`else
  logic unused_kp_dir;

  assign unused_kp_dir = ^kp_dir_main;
  assign dir_main      = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (kp_start)        state_next = ACCUM;
      ACCUM:   if (xfer && s_last)  state_next = FLUSH;
      FLUSH:                        state_next = DRAIN;
      DRAIN:   if (beat && d_last)  state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Sample pipeline stage; out-of-range directions never reach the adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= 1'b0;
      pipe     <= '0;
    end else begin
      pipe_vld <= xfer && !q_err;
      if (xfer) begin
        pipe.idx <= {s_sub, q_bin};
        pipe.mag <= s_mag;
      end
    end
  end

  // Saturating add for the bin currently in the pipeline.
  assign sum = {1'b0, acc[pipe.idx]} + (ACC_W + 1)'(pipe.mag);
  assign upd = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

  // Histogram storage.
  always_ff @(posedge clk) begin
    if (rst || kp_go) begin
      for (int unsigned i = 0; i < DESC_LEN; i++) acc[i] <= '0;
    end else if (pipe_vld) begin
      acc[pipe.idx] <= upd;
    end
  end

  // Registered stream/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready <= 1'b0;
      busy    <= 1'b0;
      err_dir <= 1'b0;
      d_valid <= 1'b0;
      d_data  <= '0;
      d_idx   <= '0;
      d_last  <= 1'b0;
    end else begin
      s_ready <= (state_next == ACCUM);
      busy    <= (state_next != IDLE);
      err_dir <= xfer && q_err;
      d_valid <= (state_next == DRAIN);
      if (state == FLUSH) begin
        // The last sample lands in acc on this same edge, so forward it.
        d_idx  <= '0;
        d_last <= 1'b0;
        d_data <= (pipe_vld && pipe.idx == '0) ? upd : acc[0];
      end else if (beat && !d_last) begin
        d_idx  <= d_idx + IDX_W'(1);
        d_last <= (d_idx == IDX_W'(DESC_LEN - 2));
        d_data <= acc[d_idx + IDX_W'(1)];
      end else if (beat) begin
        d_idx  <= '0;
        d_last <= 1'b0;
        d_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_desc_hist_ctrl.sv
// Directed bench for desc_hist_ctrl; expectations adapt to DESC_ROT_EN.
`timescale 1ns/1ps
module tb_desc_hist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        kp_start;
  logic [5:0]  kp_dir_main;
  logic        s_valid;
  logic        s_ready;
  logic [5:0]  s_dir;
  logic [7:0]  s_mag;
  logic [3:0]  s_sub;
  logic        s_last;
  logic        d_valid;
  logic        d_ready;
  logic [15:0] d_data;
  logic [6:0]  d_idx;
  logic        d_last;
  logic        busy;
  logic        err_dir;

  always #5 clk = ~clk;

  desc_hist_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .kp_start    (kp_start),
    .kp_dir_main (kp_dir_main),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_dir       (s_dir),
    .s_mag       (s_mag),
    .s_sub       (s_sub),
    .s_last      (s_last),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_data      (d_data),
    .d_idx       (d_idx),
    .d_last      (d_last),
    .busy        (busy),
    .err_dir     (err_dir)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] got   [128];
  logic [15:0] exp_d [128];
  int dr_beats, dr_order, dr_stab, dr_last, dr_stall, dr_timeout;
  int stall_cnt;

  task automatic do_reset();
    rst = 1'b1; kp_start = 1'b0; kp_dir_main = '0;
    s_valid = 1'b0; s_dir = '0; s_mag = '0; s_sub = '0; s_last = 1'b0;
    d_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 128; i++) begin
      exp_d[i] = '0;
      got[i]   = 16'hDEAD;
    end
  endtask

  task automatic start_kp(input logic [5:0] main);
    kp_start = 1'b1; kp_dir_main = main;
    @(negedge clk);
    kp_start = 1'b0;
  endtask

  task automatic send(input logic [5:0] dir, input logic [7:0] mag,
                      input logic [3:0] sub, input logic last);
    if (s_ready !== 1'b1) stall_cnt++;
    s_valid = 1'b1; s_dir = dir; s_mag = mag; s_sub = sub; s_last = last;
    @(negedge clk);
  endtask

  task automatic end_burst();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Collects up to 128 beats into got[]; records ordering/stability faults.
  task automatic drain(input bit throttle, input int stop_at, input bit kp_on_last);
    int          cyc = 0;
    bit          pstall = 1'b0;
    logic [15:0] pd = '0;
    logic [6:0]  pi = '0;
    logic        pl = 1'b0;
    dr_beats = 0; dr_order = 0; dr_stab = 0; dr_last = 0; dr_stall = 0; dr_timeout = 0;
    d_ready = 1'b0;
    while (d_valid !== 1'b1 && cyc < 16) begin
      @(negedge clk); cyc++;
    end
    if (d_valid !== 1'b1) begin
      dr_timeout = 1;
      return;
    end
    cyc = 0;
    while (dr_beats < 128) begin
      if (cyc > 4000 || d_valid !== 1'b1) begin
        dr_timeout = 1;
        break;
      end
      if (pstall && {d_data, d_idx, d_last} !== {pd, pi, pl}) dr_stab++;
      if (d_idx !== 7'(dr_beats)) dr_order++;
      if (d_last !== (dr_beats == 127)) dr_last++;
      if (dr_beats == stop_at) break;
      got[dr_beats] = d_data;
      d_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!d_ready) dr_stall++;
      kp_start    = kp_on_last && d_ready && (dr_beats == 127);
      kp_dir_main = 6'd7;
      pstall = !d_ready; pd = d_data; pi = d_idx; pl = d_last;
      if (d_ready) dr_beats++;
      @(negedge clk); cyc++;
      kp_start = 1'b0;
    end
    d_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; kp_start = 1'b0; kp_dir_main = '0;
    s_valid = 1'b0; s_dir = '0; s_mag = '0; s_sub = '0; s_last = 1'b0;
    d_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, d_valid, d_data, d_idx, d_last, busy, err_dir} !== 27'd0) begin
      errors++;
      $display("FAIL reset_during: got %h expected 0",
               {s_ready, d_valid, d_data, d_idx, d_last, busy, err_dir});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, d_valid, d_data, d_idx, d_last, busy, err_dir} !== 27'd0) begin
      errors++;
      $display("FAIL reset_after: got %h expected 0",
               {s_ready, d_valid, d_data, d_idx, d_last, busy, err_dir});
    end
  endtask

  task automatic test_single();
    do_reset(); clear_exp(); stall_cnt = 0;
    exp_d[17] = 16'd10;
    start_kp(6'd0);
    checks++;
    if ({busy, s_ready} !== 2'b11) begin
      errors++; $display("FAIL single_accum_flags: got %b expected 11", {busy, s_ready});
    end
    send(6'd5, 8'd10, 4'd2, 1'b1);
    end_burst();
    checks++;
    if ({busy, s_ready, d_valid} !== 3'b100) begin
      errors++; $display("FAIL single_flush_flags: got %b expected 100", {busy, s_ready, d_valid});
    end
    drain(1'b0, -1, 1'b1);
    checks++;
    if (dr_timeout != 0 || dr_beats != 128 || dr_order != 0 || dr_last != 0) begin
      errors++;
      $display("FAIL single_stream: timeout=%0d beats=%0d order=%0d last=%0d expected 0/128/0/0",
               dr_timeout, dr_beats, dr_order, dr_last);
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        errors++; $display("FAIL single_idx%0d: got %h expected %h", i, got[i], exp_d[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({d_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL single_kp_on_last_ignored: got %b expected 00", {d_valid, busy});
    end
  endtask

  task automatic test_rotation();
    do_reset(); clear_exp();
`ifdef DESC_ROT_EN
    exp_d[0] = 16'd7;
`else
    exp_d[0] = 16'd3;
    exp_d[7] = 16'd4;
`endif
    start_kp(6'd34);
    send(6'd0, 8'd3, 4'd0, 1'b0);
    send(6'd33, 8'd4, 4'd0, 1'b1);
    end_burst();
    drain(1'b0, -1, 1'b0);
    checks++;
    if (dr_timeout != 0 || dr_beats != 128 || dr_order != 0 || dr_last != 0) begin
      errors++;
      $display("FAIL rot_stream: timeout=%0d beats=%0d order=%0d last=%0d expected 0/128/0/0",
               dr_timeout, dr_beats, dr_order, dr_last);
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        errors++; $display("FAIL rot_idx%0d: got %h expected %h", i, got[i], exp_d[i]);
      end
    end
    checks++;
    if (d_valid !== 1'b0) begin
      errors++; $display("FAIL rot_dvalid_after: got %b expected 0", d_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_exp(); stall_cnt = 0;
    exp_d[124] = 16'hFFFF;
    start_kp(6'd0);
    for (int i = 0; i < 300; i++) send(6'd17, 8'd255, 4'd15, 1'(i == 299));
    end_burst();
    checks++;
    if (stall_cnt != 0) begin
      errors++; $display("FAIL b2b_no_stall: got %0d stalls expected 0", stall_cnt);
    end
    drain(1'b0, -1, 1'b0);
    checks++;
    if (dr_timeout != 0 || dr_beats != 128 || dr_order != 0 || dr_last != 0) begin
      errors++;
      $display("FAIL b2b_stream: timeout=%0d beats=%0d order=%0d last=%0d expected 0/128/0/0",
               dr_timeout, dr_beats, dr_order, dr_last);
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        errors++; $display("FAIL b2b_idx%0d: got %h expected %h", i, got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_err_dir();
    do_reset(); clear_exp();
    exp_d[0] = 16'd5;
    start_kp(6'd0);
    send(6'd0, 8'd5, 4'd0, 1'b0);
    kp_start = 1'b1; kp_dir_main = 6'd10;
    send(6'd40, 8'd9, 4'd3, 1'b0);
    kp_start = 1'b0;
    checks++;
    if (err_dir !== 1'b1) begin
      errors++; $display("FAIL err_dir_pulse: got %b expected 1", err_dir);
    end
    send(6'd2, 8'd0, 4'd0, 1'b1);
    end_burst();
    checks++;
    if (err_dir !== 1'b0) begin
      errors++; $display("FAIL err_dir_one_cycle: got %b expected 0", err_dir);
    end
    drain(1'b0, -1, 1'b0);
    checks++;
    if (dr_timeout != 0 || dr_beats != 128 || dr_order != 0 || dr_last != 0) begin
      errors++;
      $display("FAIL err_stream: timeout=%0d beats=%0d order=%0d last=%0d expected 0/128/0/0",
               dr_timeout, dr_beats, dr_order, dr_last);
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        errors++; $display("FAIL err_idx%0d: got %h expected %h", i, got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_throttle();
    do_reset(); clear_exp();
    exp_d[44]  = 16'd7;
    exp_d[120] = 16'd1;
    exp_d[79]  = 16'd203;
    exp_d[1]   = 16'd4;
    start_kp(6'd0);
    send(6'd20, 8'd7,   4'd5,  1'b0);
    send(6'd35, 8'd1,   4'd15, 1'b0);
    send(6'd30, 8'd200, 4'd9,  1'b0);
    send(6'd33, 8'd3,   4'd9,  1'b0);
    send(6'd3,  8'd4,   4'd0,  1'b1);
    end_burst();
    drain(1'b1, -1, 1'b0);
    checks++;
    if (dr_timeout != 0 || dr_beats != 128 || dr_order != 0 || dr_last != 0) begin
      errors++;
      $display("FAIL thr_stream: timeout=%0d beats=%0d order=%0d last=%0d expected 0/128/0/0",
               dr_timeout, dr_beats, dr_order, dr_last);
    end
    checks++;
    if (dr_stab != 0) begin
      errors++; $display("FAIL thr_stable: got %0d changes while stalled expected 0", dr_stab);
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        errors++; $display("FAIL thr_idx%0d: got %h expected %h", i, got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset(); clear_exp();
    start_kp(6'd0);
    send(6'd10, 8'd50, 4'd7, 1'b1);
    end_burst();
    drain(1'b1, 60, 1'b0);
    checks++;
    if (dr_timeout != 0 || dr_beats != 60 || dr_order != 0) begin
      errors++;
      $display("FAIL mid_reach60: timeout=%0d beats=%0d order=%0d expected 0/60/0",
               dr_timeout, dr_beats, dr_order);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_valid, busy, s_ready, d_idx, d_last} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_idle: got %h expected 0", {d_valid, busy, s_ready, d_idx, d_last});
    end
    rst = 1'b0;
    @(negedge clk);
    clear_exp();
`ifdef DESC_ROT_EN
    exp_d[8] = 16'd6;
`else
    exp_d[12] = 16'd6;
`endif
    start_kp(6'd18);
    send(6'd18, 8'd6, 4'd1, 1'b1);
    end_burst();
    drain(1'b0, -1, 1'b0);
    checks++;
    if (dr_timeout != 0 || dr_beats != 128 || dr_order != 0 || dr_last != 0) begin
      errors++;
      $display("FAIL mid_new_stream: timeout=%0d beats=%0d order=%0d last=%0d expected 0/128/0/0",
               dr_timeout, dr_beats, dr_order, dr_last);
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        errors++; $display("FAIL mid_new_idx%0d: got %h expected %h", i, got[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_err_dir();
    test_throttle();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
